// File: rtl/axi_lite_vram_responder.sv
// rtl/axi_lite_vram_responder.sv - AXI4-Lite responder driving the VRAM BRAM port and owning the palette registers
module axi_lite_vram_responder #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int VRAM_WORDS = 1200,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] PALETTE_BASE = 16'h2000,
  parameter int PALETTE_WORDS = 8
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]       axi_awaddr,
  input  logic [2:0]                        axi_awprot,
  input  logic                              axi_awvalid,
  output logic                              axi_awready,
  input  logic [31:0]                       axi_wdata,
  input  logic [3:0]                        axi_wstrb,
  input  logic                              axi_wvalid,
  output logic                              axi_wready,
  output logic [1:0]                        axi_bresp,
  output logic                              axi_bvalid,
  input  logic                              axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]       axi_araddr,
  input  logic [2:0]                        axi_arprot,
  input  logic                              axi_arvalid,
  output logic                              axi_arready,
  output logic [31:0]                       axi_rdata,
  output logic [1:0]                        axi_rresp,
  output logic                              axi_rvalid,
  input  logic                              axi_rready,
  output logic                              mem_en,
  output logic [3:0]                        mem_we,
  output logic [$clog2(VRAM_WORDS)-1:0]     mem_addr,
  output logic [31:0]                       mem_wdata,
  input  logic [31:0]                       mem_rdata,
  output logic [32*PALETTE_WORDS-1:0]       palette
);

  localparam int AW   = C_AXI_ADDR_WIDTH;
  localparam int WW   = AW - 2;
  localparam int MAW  = $clog2(VRAM_WORDS);
  localparam int PIDX = $clog2(PALETTE_WORDS);

  localparam logic [WW-1:0] VRAM_WORDS_W = WW'(VRAM_WORDS);
  localparam logic [WW-1:0] PAL_BASE_W   = PALETTE_BASE[AW-1:2];
  localparam logic [WW-1:0] PAL_WORDS_W  = WW'(PALETTE_WORDS);

  localparam logic [1:0] REG_VRAM = 2'd0;
  localparam logic [1:0] REG_PAL  = 2'd1;
  localparam logic [1:0] REG_NONE = 2'd2;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_PEND = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] RD_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] region_of(input logic [WW-1:0] w);
    if (w < VRAM_WORDS_W) return REG_VRAM;
    if (w >= PAL_BASE_W && (w - PAL_BASE_W) < PAL_WORDS_W) return REG_PAL;
    return REG_NONE;
  endfunction

  function automatic logic [PIDX-1:0] pal_idx(input logic [WW-1:0] w);
    return PIDX'(w - PAL_BASE_W);
  endfunction

  logic [WW-1:0]   aw_word_q;
  logic            aw_held;
  logic [31:0]     w_data_q;
  logic [3:0]      w_strb_q;
  logic            w_held;
  logic [WW-1:0]   ar_word_q;
  logic [1:0]      rd_state;
  logic            rd_mem_live;
  logic [31:0]     rdata_q;

  logic            aw_hs, w_hs, ar_hs, wr_issue;
  logic            aw_held_nxt, w_held_nxt, bvalid_nxt;
  logic [1:0]      wr_region, rd_region;
  logic [PIDX-1:0] wr_pidx, rd_pidx;
  logic            unused;

  assign unused    = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};
  assign aw_hs     = axi_awvalid && axi_awready;
  assign w_hs      = axi_wvalid && axi_wready;
  assign ar_hs     = axi_arvalid && axi_arready;
  assign wr_issue  = aw_held && w_held && !axi_bvalid;
  assign wr_region = region_of(aw_word_q);
  assign rd_region = region_of(ar_word_q);
  assign wr_pidx   = pal_idx(aw_word_q);
  assign rd_pidx   = pal_idx(ar_word_q);

  // The first cycle of a VRAM response passes the BRAM output straight through; it is latched after that.
  assign axi_rdata = rd_mem_live ? mem_rdata : rdata_q;

  always_comb begin
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    bvalid_nxt  = axi_bvalid;
    if (aw_hs) aw_held_nxt = 1'b1;
    if (w_hs) w_held_nxt = 1'b1;
    if (axi_bvalid && axi_bready) bvalid_nxt = 1'b0;
    if (wr_issue) begin
      aw_held_nxt = 1'b0;
      w_held_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_word_q   <= '0;
      aw_held     <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      w_held      <= 1'b0;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= '0;
      ar_word_q   <= '0;
      rd_state    <= RD_IDLE;
      rd_mem_live <= 1'b0;
      rdata_q     <= '0;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rresp   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      palette     <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= '0;

      if (aw_hs) aw_word_q <= axi_awaddr[AW-1:2];
      if (w_hs) begin
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
      end
      aw_held     <= aw_held_nxt;
      w_held      <= w_held_nxt;
      axi_bvalid  <= bvalid_nxt;
      axi_awready <= !aw_held_nxt && !bvalid_nxt;
      axi_wready  <= !w_held_nxt && !bvalid_nxt;

      if (wr_issue) begin
        axi_bresp <= (wr_region == REG_NONE) ? RESP_DECERR : RESP_OKAY;
        if (wr_region == REG_VRAM) begin
          mem_en    <= 1'b1;
          mem_we    <= w_strb_q;
          mem_addr  <= aw_word_q[MAW-1:0];
          mem_wdata <= w_data_q;
        end else if (wr_region == REG_PAL) begin
          for (int i = 0; i < 4; i++) begin
            if (w_strb_q[i]) palette[32*int'(wr_pidx) + 8*i +: 8] <= w_data_q[8*i +: 8];
          end
        end
      end

      case (rd_state)
        RD_IDLE: begin
          axi_arready <= !ar_hs;
          if (ar_hs) begin
            ar_word_q <= axi_araddr[AW-1:2];
            rd_state  <= RD_PEND;
          end
        end
        // A write issuing in the same cycle owns the BRAM port, so the read waits one cycle.
        RD_PEND: begin
          axi_arready <= 1'b0;
          if (!wr_issue) begin
            if (rd_region == REG_VRAM) begin
              mem_en   <= 1'b1;
              mem_addr <= ar_word_q[MAW-1:0];
            end
            rd_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          axi_arready <= 1'b0;
          axi_rvalid  <= 1'b1;
          axi_rresp   <= (rd_region == REG_NONE) ? RESP_DECERR : RESP_OKAY;
          rd_mem_live <= (rd_region == REG_VRAM);
          rdata_q     <= (rd_region == REG_PAL) ? palette[32*int'(rd_pidx) +: 32] : 32'h0;
          rd_state    <= RD_RESP;
        end
        default: begin
          if (rd_mem_live) begin
            rdata_q     <= mem_rdata;
            rd_mem_live <= 1'b0;
          end
          axi_arready <= axi_rready;
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            rd_state   <= RD_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_vram_responder.sv
// tb/tb_axi_lite_vram_responder.sv - self-checking bench for axi_lite_vram_responder
module tb_axi_lite_vram_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]  awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [15:0]  araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic         mem_en;
  logic [3:0]   mem_we;
  logic [10:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;
  logic [255:0] palette;

  int n_cmp = 0;
  int n_fail = 0;
  int we_count = 0;

  logic [31:0] vram_m [0:1199] = '{default: 32'h0};

  axi_lite_vram_responder dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .palette(palette)
  );

  // External BRAM port A: synchronous read, byte-enabled write.
  always @(posedge clk) begin
    if (mem_en && mem_addr < 11'd1200) begin
      mem_rdata <= vram_m[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) vram_m[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    if (mem_we != 4'h0) we_count <= we_count + 1;
  end

  logic [88:0] outs;
  assign outs = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
                 mem_en, mem_we, mem_addr, mem_wdata};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    logic aw_done, w_done, aw_fire, w_fire;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire) begin wvalid = 1'b0; w_done = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("write_handshakes", {aw_done, w_done}, 2'b11);
    bready = 1'b1;
    for (int c = 0; c < 20 && !bvalid; c++) @(negedge clk);
    check("bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic done, fire;
    araddr = a; arvalid = 1'b1; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      fire = arvalid && arready;
      @(negedge clk);
      if (fire) begin arvalid = 1'b0; done = 1'b1; end
    end
    arvalid = 1'b0;
    check("read_handshake", done, 1'b1);
    rready = 1'b1;
    for (int c = 0; c < 20 && !rvalid; c++) @(negedge clk);
    check("rvalid_seen", rvalid, 1'b1);
    d = rdata; resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   resp;
    logic [31:0]  d;
    logic [255:0] pal_exp;

    vecs[0]  = '{1'b1, 16'h0008, 32'h11223344, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 16'h0008, 32'h0000AB00, 4'h2, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h7A107910};
    vecs[3]  = '{1'b0, 16'h2004, 32'h0,        4'h0, 2'b00, 32'h0FFF00F0};
    vecs[4]  = '{1'b1, 16'h12BF, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 16'h12BC, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 16'h12C0, 32'h12345678, 4'hF, 2'b11, 32'h0};
    vecs[7]  = '{1'b0, 16'h12C0, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[8]  = '{1'b1, 16'h201F, 32'hA5A5A5A5, 4'h9, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 16'h201C, 32'h0,        4'h0, 2'b00, 32'hA50000A5};
    vecs[10] = '{1'b1, 16'h2020, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0};
    vecs[11] = '{1'b0, 16'h2020, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[12] = '{1'b1, 16'h1FFC, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0};
    vecs[13] = '{1'b0, 16'h1FFC, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[14] = '{1'b1, 16'h3000, 32'h87654321, 4'hF, 2'b11, 32'h0};
    vecs[15] = '{1'b0, 16'h3000, 32'h0,        4'h0, 2'b11, 32'h0};
    vecs[16] = '{1'b1, 16'h0004, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
    vecs[17] = '{1'b0, 16'h0004, 32'h0,        4'h0, 2'b00, 32'h7A107910};
    vecs[18] = '{1'b0, 16'h2000, 32'h0,        4'h0, 2'b00, 32'h0};

    // Reset held with valids asserted
    awaddr = 16'h0040; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs, '0);
    check("reset_palette", palette, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {awready, wready}, 2'b11);
    check("post_reset_palette", palette, '0);
    awvalid = 1'b0; wvalid = 1'b0;

    // AW and W together, VRAM word 1
    awaddr = 16'h0004; wdata = 32'h7A107910; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("b_ready_drop", {awready, wready, bvalid, mem_en}, 4'b0000);
    @(negedge clk);
    check("b_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 4'hF, 11'd1, 32'h7A107910});
    check("b_resp", {bvalid, bresp}, 3'b100);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", {bvalid, mem_en, mem_we}, 6'b0);
    check("b_ready_back", {awready, wready}, 2'b11);

    // W leads AW by 3 cycles, palette word 1, bready held off
    wdata = 32'h0FFF00F0; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("c_wready_low", {wready, awready}, 2'b01);
    repeat (2) @(negedge clk);
    check("c_waiting", {wready, bvalid}, 2'b00);
    check("c_pal_unchanged", palette, '0);
    awaddr = 16'h2004; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("c_not_issued", {bvalid, palette}, '0);
    @(negedge clk);
    check("c_resp", {bvalid, bresp}, 3'b100);
    check("c_palette", palette, 256'h0FFF00F0 << 32);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("c_hold%0d", k), {bvalid, awready, wready}, 3'b100);
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("c_bdone", bvalid, 1'b0);

    // Table of independent transactions
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
      end else begin
        do_read(vecs[i].addr, d, resp);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      end
    end
    check("vram_we_pulses", we_count, 4);
    pal_exp = (256'h0FFF00F0 << 32) | (256'hA50000A5 << 224);
    check("table_palette", palette, pal_exp);

    // Timed read of the byte-merged word with rready held off
    araddr = 16'h0008; arvalid = 1'b1;
    check("d_arready", arready, 1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    check("d_n1", {rvalid, mem_en}, 2'b00);
    @(negedge clk);
    check("d_issue", {rvalid, mem_en, mem_we, mem_addr}, {1'b0, 1'b1, 4'h0, 11'd2});
    @(negedge clk);
    check("d_data", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'h1122AB44});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("d_stable%0d", k), {rvalid, rresp, rdata, arready}, {1'b1, 2'b00, 32'h1122AB44, 1'b0});
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("d_rdone", rvalid, 1'b0);

    // Write and read of the same VRAM word in one cycle
    do_write(16'h0010, 32'h55555555, 4'hF, resp);
    check("f_pre_bresp", resp, 2'b00);
    awaddr = 16'h0010; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 16'h0010;
    check("f_all_ready", {awready, wready, arready}, 3'b111);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("f_write", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 4'hF, 11'd4, 32'hCAFEF00D});
    check("f_rv_n2", rvalid, 1'b0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("f_read_issue", {mem_en, mem_we, mem_addr, rvalid, bvalid}, {1'b1, 4'h0, 11'd4, 1'b0, 1'b0});
    @(negedge clk);
    check("f_data", {rvalid, rresp, rdata}, {1'b1, 2'b00, 32'hCAFEF00D});
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("f_rdone", rvalid, 1'b0);

    // Asynchronous reset during an outstanding write response
    awaddr = 16'h2000; wdata = 32'h13579BDF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("g_pre_bvalid", bvalid, 1'b1);
    check("g_pre_palette", palette, pal_exp | 256'h13579BDF);
    #2 rst_n = 1'b0;
    #1;
    check("g_async_outs", outs, '0);
    check("g_async_palette", palette, '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_vram_responder.md
Name: axi_lite_vram_responder

Overview:
AXI4-Lite responder (slave) front end for the HDMI text controller. It accepts bus writes and reads from the MicroBlaze master and drives the byte-strobed VRAM port of an external dual-port BRAM (port A). It also owns the 8-word color palette register file and exports it to the draw logic. Both directions support independent channel handshakes, backpressure and fixed read latency.

Parameters:
C_AXI_DATA_WIDTH, 32, bus data width; only 32 is supported.
C_AXI_ADDR_WIDTH, 16, bus byte-address width.
VRAM_WORDS, 1200, number of 32-bit VRAM words, byte addresses 0x0000-0x12BF.
PALETTE_BASE, 16'h2000, byte address of palette word 0.
PALETTE_WORDS, 8, number of palette words.

Ports:
axi_aclk  in  1  sole clock
axi_aresetn  in  1  reset, asynchronous, active-low
axi_awaddr/axi_awprot/axi_awvalid  in  ADDR/3/1  AW channel; awprot is ignored
axi_awready  out  1  AW accept
axi_wdata/axi_wstrb/axi_wvalid  in  32/4/1  W channel
axi_wready  out  1  W accept
axi_bresp/axi_bvalid  out  2/1  write response
axi_bready  in  1  master ready for response
axi_araddr/axi_arprot/axi_arvalid  in  ADDR/3/1  AR channel; arprot is ignored
axi_arready  out  1  AR accept
axi_rdata/axi_rresp/axi_rvalid  out  32/2/1  read data channel
axi_rready  in  1  master ready for read data
mem_en  out  1  VRAM port enable
mem_we  out  4  VRAM byte write enables
mem_addr  out  11  VRAM word address
mem_wdata  out  32  VRAM write data
mem_rdata  in  32  VRAM read data, valid one cycle after mem_en
palette  out  256  palette words; word k is at bits [32k+31:32k]

Behaviour:
- Reset (async assert) drives every output to 0 immediately: ready and valid signals, bresp, rresp, rdata, mem_* and palette. Any in-flight transaction is discarded.
- Decode uses word = addr[ADDR-1:2]; addr[1:0] is ignored.
  - VRAM if word < VRAM_WORDS.
  - PALETTE if (addr - PALETTE_BASE) >> 2 < PALETTE_WORDS and addr >= PALETTE_BASE.
  - Otherwise UNMAPPED.
- Write path:
  - AW and W are captured independently into one-entry holds.
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid. Both are registered and drop the cycle after their handshake.
  - AW and W in the same cycle is legal. Either channel may arrive any number of cycles before the other.
  - In the first cycle with both holds full and bvalid=0 (cycle N), the write issues at the N+1 edge:
    - VRAM: mem_en=1, mem_we=wstrb, mem_addr and mem_wdata set for exactly one cycle.
    - PALETTE: bytes with wstrb[i]=1 are updated.
    - UNMAPPED: no state change.
  - bvalid rises in the same cycle the write issues. bresp is 2'b00 (OKAY), or 2'b11 (DECERR) when UNMAPPED.
  - bvalid holds until a bready handshake; both holds clear at issue.
  - wstrb=0 changes no bytes and returns OKAY.
- Read path:
  - arready = idle && !rvalid.
  - After an AR handshake in cycle N, the read issues in N+1 (VRAM: mem_en=1, mem_we=0).
  - rvalid rises in N+2 with rdata = mem_rdata, the palette word, or 0 when UNMAPPED. rresp is 2'b00, or 2'b11 when UNMAPPED. Palette and unmapped reads also take N+2, so latency is uniform.
  - rdata, rresp and rvalid hold stable until rready. The next AR is accepted only after rvalid falls.
- VRAM port collision: when a write issue and a read issue land in the same cycle, the write wins. The read issues one cycle later and its rvalid is delayed by one cycle.
- Read-after-write to the same word returns the new data, because the write issues first.

Test Plan:
- Reset with awvalid=wvalid=1 held -> all outputs 0 during reset. After release, awready=wready=1 on the first edge and palette=0.
- Write 0x0004 data 0x7A107910, wstrb=F, AW and W in the same cycle -> one-cycle mem_we=F, mem_addr=1, mem_wdata=0x7A107910; bvalid=1, bresp=00. Then bready=1 -> bvalid falls.
- W leads AW by 3 cycles; write 0x2004 data 0x0FFF00F0 -> wready low while waiting; palette[63:32]=0x0FFF00F0 only after AW arrives. With bready held low for 5 cycles, bvalid stays high and awready/wready stay 0.
- Byte writes to 0x0008 over old 0x11223344: wstrb=4'b0010 with 0x0000AB00, then read 0x0008 -> rdata=0x1122AB44 two cycles after the AR handshake, rresp=00. With rready delayed 4 cycles, rdata stays stable.
- Write and read 0x3000 (UNMAPPED) -> bresp=11 with no mem_we and no palette change; rdata=0, rresp=11.
- Write 0x0010 and read 0x0010 arriving in the same cycle -> write issues first and rvalid is delayed by one cycle; rdata equals the new data.
